// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage (EX, MW) integer datapath with a register file and a
// handshaked data-memory port. Define FORWARD_EN to forward operands at accept instead of stalling.
module pipe_datapath #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               regWrite,
  input  logic               memWrite,
  input  logic               memRead,
  input  logic               ALUsrc,
  input  logic [2:0]         ALUctrl,
  input  logic [A_WIDTH-1:0] rs1,
  input  logic [A_WIDTH-1:0] rs2,
  input  logic [A_WIDTH-1:0] rd,
  input  logic [D_WIDTH-1:0] ImmOp,
  output logic               mem_req,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               eq,
  output logic [D_WIDTH-1:0] result,
  output logic               result_valid,
  output logic [D_WIDTH-1:0] a0
);

  localparam int NREGS = 1 << A_WIDTH;
  localparam logic [D_WIDTH-1:0] D_ZERO = {D_WIDTH{1'b0}};
  localparam logic [A_WIDTH-1:0] A_ZERO = {A_WIDTH{1'b0}};

  typedef enum logic [0:0] {MW_IDLE = 1'b0, MW_WAIT = 1'b1} mw_state_t;

  function automatic logic [D_WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [D_WIDTH-1:0] a,
                                               input logic [D_WIDTH-1:0] b);
    logic [D_WIDTH-1:0] r;
    r = D_ZERO;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = {{(D_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b110:  r = a << b[4:0];
      3'b111:  r = a >> b[4:0];
      default: r = a + b;
    endcase
    return r;
  endfunction

  logic [D_WIDTH-1:0] rf_r [NREGS];

  logic               ex_valid_r, ex_regwrite_r, ex_memwrite_r, ex_memread_r;
  logic [2:0]         ex_aluctrl_r;
  logic [A_WIDTH-1:0] ex_rd_r;
  logic [D_WIDTH-1:0] ex_a_r, ex_b_r, ex_sd_r;

  logic               mw_valid_r, mw_regwrite_r, mw_memwrite_r, mw_memread_r;
  logic [A_WIDTH-1:0] mw_rd_r;
  logic [D_WIDTH-1:0] mw_alu_r, mw_sd_r;
  mw_state_t          mw_state_r, mw_state_next_s;
  logic               ready_en_r;

  logic               mw_wait_s, mw_retire_s, wb_en_s, ex_adv_s, enter_mem_s, accept_s;
  logic               rs2_used_s, ex_hit_s, mw_hit_s, hazard_s;
  logic [D_WIDTH-1:0] ex_alu_s, wb_value_s, src_a_s, src_b_s, op_b_s;

  assign ex_alu_s    = alu_f(ex_aluctrl_r, ex_a_r, ex_b_r);
  assign mw_wait_s   = (mw_state_r == MW_WAIT);
  assign mw_retire_s = mw_valid_r & (~mw_wait_s | mem_ack);
  assign wb_value_s  = mw_memread_r ? mem_rdata : mw_alu_r;
  assign wb_en_s     = mw_retire_s & mw_regwrite_r & (mw_rd_r != A_ZERO);
  assign ex_adv_s    = ex_valid_r & (~mw_valid_r | mw_retire_s);
  assign enter_mem_s = ex_adv_s & (ex_memread_r | ex_memwrite_r);
  assign accept_s    = in_valid & in_ready;

  // Source operands: EX result (forwarding builds only), then retiring write, then register file.
  always_comb begin
    if (rs1 == A_ZERO) src_a_s = D_ZERO;
`ifdef FORWARD_EN
    else if (ex_valid_r && ex_regwrite_r && !ex_memread_r && ex_rd_r == rs1) src_a_s = ex_alu_s;
`endif
    else if (wb_en_s && mw_rd_r == rs1) src_a_s = wb_value_s;
    else src_a_s = rf_r[rs1];

    if (rs2 == A_ZERO) src_b_s = D_ZERO;
`ifdef FORWARD_EN
    else if (ex_valid_r && ex_regwrite_r && !ex_memread_r && ex_rd_r == rs2) src_b_s = ex_alu_s;
`endif
    else if (wb_en_s && mw_rd_r == rs2) src_b_s = wb_value_s;
    else src_b_s = rf_r[rs2];

    op_b_s = ALUsrc ? ImmOp : src_b_s;
  end

  // Operand hazards against the incoming instruction.
  always_comb begin
    rs2_used_s = ~ALUsrc | memWrite;
    ex_hit_s = (ex_rd_r != A_ZERO) & ((ex_rd_r == rs1) | (rs2_used_s & (ex_rd_r == rs2)));
    mw_hit_s = (mw_rd_r != A_ZERO) & ((mw_rd_r == rs1) | (rs2_used_s & (mw_rd_r == rs2)));
`ifdef FORWARD_EN
    // A pending memory op in MW that writes a register has no value to forward yet.
    hazard_s = (ex_valid_r & ex_memread_r & ex_hit_s) |
               (mw_valid_r & mw_wait_s & ~mem_ack & (mw_memread_r | mw_regwrite_r) & mw_hit_s);
`else
    hazard_s = (ex_valid_r & (ex_regwrite_r | ex_memread_r) & ex_hit_s) |
               (mw_valid_r & (mw_regwrite_r | mw_memread_r) & mw_hit_s);
`endif
  end

  assign in_ready = ready_en_r & ~(ex_valid_r & ~ex_adv_s) & ~hazard_s;

  // MW state transition.
  always_comb begin
    mw_state_next_s = mw_state_r;
    case (mw_state_r)
      MW_IDLE: begin
        if (enter_mem_s) mw_state_next_s = MW_WAIT;
        else             mw_state_next_s = MW_IDLE;
      end
      MW_WAIT: begin
        if (enter_mem_s)  mw_state_next_s = MW_WAIT;
        else if (mem_ack) mw_state_next_s = MW_IDLE;
        else              mw_state_next_s = MW_WAIT;
      end
      default: mw_state_next_s = MW_IDLE;
    endcase
  end

  // MW state register and accept enable after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mw_state_r <= MW_IDLE;
      ready_en_r <= 1'b0;
    end else begin
      mw_state_r <= mw_state_next_s;
      ready_en_r <= 1'b1;
    end
  end

  // EX stage latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r    <= 1'b0;
      ex_regwrite_r <= 1'b0;
      ex_memwrite_r <= 1'b0;
      ex_memread_r  <= 1'b0;
      ex_aluctrl_r  <= 3'b000;
      ex_rd_r       <= A_ZERO;
      ex_a_r        <= D_ZERO;
      ex_b_r        <= D_ZERO;
      ex_sd_r       <= D_ZERO;
    end else if (accept_s) begin
      ex_valid_r    <= 1'b1;
      ex_regwrite_r <= regWrite;
      ex_memwrite_r <= memWrite;
      ex_memread_r  <= memRead;
      ex_aluctrl_r  <= ALUctrl;
      ex_rd_r       <= rd;
      ex_a_r        <= src_a_s;
      ex_b_r        <= op_b_s;
      ex_sd_r       <= src_b_s;
    end else if (ex_adv_s) begin
      ex_valid_r    <= 1'b0;
    end
  end

  // MW stage latch; contents only change on advance or retire so a memory stall holds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mw_valid_r    <= 1'b0;
      mw_regwrite_r <= 1'b0;
      mw_memwrite_r <= 1'b0;
      mw_memread_r  <= 1'b0;
      mw_rd_r       <= A_ZERO;
      mw_alu_r      <= D_ZERO;
      mw_sd_r       <= D_ZERO;
    end else if (ex_adv_s) begin
      mw_valid_r    <= 1'b1;
      mw_regwrite_r <= ex_regwrite_r;
      mw_memwrite_r <= ex_memwrite_r;
      mw_memread_r  <= ex_memread_r;
      mw_rd_r       <= ex_rd_r;
      mw_alu_r      <= ex_alu_s;
      mw_sd_r       <= ex_sd_r;
    end else if (mw_retire_s) begin
      mw_valid_r    <= 1'b0;
    end
  end

  // Register file writeback; entry 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_r <= '{default: D_ZERO};
    end else if (wb_en_s) begin
      rf_r[mw_rd_r] <= wb_value_s;
    end
  end

  assign mem_req      = mw_valid_r & mw_wait_s;
  assign mem_we       = mem_req & mw_memwrite_r;
  assign mem_addr     = mem_req ? mw_alu_r : D_ZERO;
  assign mem_wdata    = mem_req ? mw_sd_r : D_ZERO;
  assign result_valid = mw_retire_s;
  assign result       = mw_retire_s ? wb_value_s : D_ZERO;
  assign eq           = ex_valid_r & (ex_a_r == ex_b_r);
  assign a0           = rf_r[A_WIDTH'(10)];

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 SHALL have parameter A_WIDTH, default 5: register address width; register file holds 2**A_WIDTH entries.
REQ-002 SHALL have parameter D_WIDTH, default 32: data, immediate and memory address width.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: in_valid  in  1  instruction present; in_ready  out  1  instruction accepted when both high at a clk edge.
REQ-006 SHALL have ports: regWrite, memWrite, memRead, ALUsrc  in  1 each  per-instruction controls.
REQ-007 SHALL have ports: ALUctrl  in  3  ALU operation; rs1, rs2, rd  in  A_WIDTH  register addresses; ImmOp  in  D_WIDTH  immediate.
REQ-008 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr, mem_wdata  out  D_WIDTH; mem_rdata  in  D_WIDTH; mem_ack  in  1  data-memory handshake.
REQ-009 SHALL have ports: eq  out  1  EX operands equal; result  out  D_WIDTH  retiring value; result_valid  out  1  retire strobe; a0  out  D_WIDTH  register 10 contents.

Function
REQ-010 SHALL implement two stages: EX (latched operands, combinational ALU) and MW (memory access, writeback), each with a valid bit.
REQ-011 On accept, SHALL latch controls, rd, operand A = reg[rs1], store data = reg[rs2], and operand B = ALUsrc ? ImmOp : reg[rs2] into EX.
REQ-012 ALUctrl SHALL select: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed slt (result 1/0), 110 sll by B[4:0], 111 srl by B[4:0]; results truncated to D_WIDTH.
REQ-013 eq SHALL be (A == B) while EX valid, else 0.
REQ-014 EX SHALL advance into MW when MW is empty or retiring that cycle.
REQ-015 Non-memory instruction in MW SHALL retire in its first MW cycle: result = ALU value, result_valid = 1.
REQ-016 MW FSM states SHALL be IDLE, WAIT: entering MW with memRead|memWrite moves to WAIT; mem_req = 1, mem_we = memWrite, mem_addr = ALU value, mem_wdata = store data, held stable until mem_ack.
REQ-017 In WAIT, mem_ack SHALL retire the instruction that cycle (result = mem_rdata for load, ALU value for store) and return to IDLE; mem_ack outside WAIT SHALL be ignored.
REQ-018 Retire with regWrite and rd != 0 SHALL write result to reg[rd] at that edge; reg[0] SHALL read 0 always.
REQ-019 Non-memory latency SHALL be: accept at edge N, result_valid high in the cycle ending at edge N+2, register written at edge N+2.
REQ-020 in_ready SHALL be 0 while EX is valid and cannot advance (MW in WAIT without mem_ack).
REQ-021 Register reads at accept SHALL see a write retiring at the same edge (write-before-read bypass).
REQ-022 Load-use: in_ready SHALL be 0 while a load in EX or an un-acked load in MW has rd != 0 equal to incoming rs1, or to rs2 when rs2 is used (ALUsrc = 0 or memWrite).
REQ-023 Memory stall of arbitrary length SHALL hold EX and MW contents unchanged.

Reset
REQ-024 rst_n low SHALL asynchronously clear EX/MW valid bits, all registers to 0, FSM to IDLE; outputs mem_req, mem_we, result_valid, eq, in_ready = 0, result, mem_addr, mem_wdata = 0.
REQ-025 Reset mid-WAIT SHALL abandon the access without retire; in_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-026 With FORWARD_EN defined, operands at accept SHALL be forwarded from a non-load EX instruction (ALU value) and MW retiring value, priority EX over MW over register file, rd != 0 only.
REQ-027 Without FORWARD_EN, in_ready SHALL be 0 while any valid EX or MW instruction with regWrite and rd != 0 matches a used source register.

Verification
REQ-028 Reset, then add x1 = x0 + imm 5 and add x10 = x1 + imm 3 back-to-back -> with FORWARD_EN no stall, a0 = 8 two cycles after second accept; without, one or two stall cycles, same final a0.
REQ-029 Store x10 (8) to address 16 then load x2 from 16, mem_ack delayed 3 cycles -> mem_req/mem_addr = 16 stable, in_ready 0 during waits, result = 8 on load retire.
REQ-030 Load x3 followed by add x4 = x3 + x3 -> in_ready 0 until load retires; x4 = 2 * loaded value.
REQ-031 Write x0 = imm 7 then read x0 -> result_valid pulses with 7, x0 still reads 0.
REQ-032 ALU sweep A = 0x8000_0000, B = 1 -> slt = 1, sub = 0x7FFF_FFFF, srl = 0x4000_0000, eq = 0; A = B = 9 -> eq = 1.
REQ-033 Drop rst_n during WAIT -> mem_req 0 immediately, no result_valid, in_ready 1 after release.
